// File: rtl/sine_wave_generator.sv
// Direct-digital-synthesis sine source: 16-bit phase accumulator driving a quarter-wave
// table with quadrant mirroring, producing one registered signed sample per clock.
module sine_wave_generator (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [15:0]        freq,
  output logic signed [15:0] dataout
);

  localparam real Pi = 3.14159265358979323846;

  // Quarter-wave table: entries 0..256 cover sin(0)..sin(pi/2) inclusive, so both
  // mirrored quadrants can reach their peak without a special case.
  logic [15:0] quarter [257];

  for (genvar k = 0; k < 257; k++) begin : g_rom
    localparam real         Amp = 32767.0 * $sin(2.0 * Pi * real'(k) / 1024.0);
    localparam logic [15:0] Val = 16'($rtoi(Amp + 0.5));
    assign quarter[k] = Val;
  end

  logic [15:0]        phase;
  logic [9:0]         idx;
  logic [8:0]         addr;
  logic [15:0]        mag;
  logic signed [15:0] sample;

  assign idx = phase[15:6];

  always_comb begin
    addr   = 9'd0;
    mag    = 16'd0;
    sample = 16'sd0;
    // Quadrants 1 and 3 read the table backwards; quadrants 2 and 3 negate.
    if (idx[8]) begin
      addr = 9'd256 - {1'b0, idx[7:0]};
    end else begin
      addr = {1'b0, idx[7:0]};
    end
    mag    = quarter[addr];
    sample = idx[9] ? -$signed(mag) : $signed(mag);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase   <= 16'd0;
      dataout <= 16'sd0;
    end else begin
      phase   <= phase + freq;
      dataout <= sample;
    end
  end

endmodule

// File: tb/tb_sine_wave_generator.sv
// Directed bench for sine_wave_generator: reset, quadrature, unit-step, frozen-phase
// and long-run frequency checks against hand values and a phase/table model.
module tb_sine_wave_generator;

  logic               clk;
  logic               reset_n;
  logic [15:0]        freq;
  logic signed [15:0] dataout;

  int unsigned n_assert;
  int unsigned n_fail;
  logic [15:0] ph;

  sine_wave_generator dut (
    .clk     (clk),
    .reset_n (reset_n),
    .freq    (freq),
    .dataout (dataout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int s_ref(input int k);
    real x;
    x = 32767.0 * $sin(2.0 * 3.14159265358979323846 * real'(k) / 1024.0);
    if (x >= 0.0) return $rtoi(x + 0.5);
    else return -$rtoi(-x + 0.5);
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One edge: compare against the model, then advance the model phase.
  task automatic step(input string tag);
    int exp;
    exp = s_ref(int'(ph[15:6]));
    tick();
    check(tag, int'(dataout), exp);
    ph = ph + freq;
  endtask

  task automatic do_reset(input logic [15:0] f);
    @(negedge clk);
    reset_n = 1'b0;
    freq    = f;
    ph      = 16'd0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  int quad_exp [8];
  int cnt;
  int prev;
  int cur;

  initial begin
    n_assert = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    freq     = 16'd0;
    ph       = 16'd0;
    quad_exp = '{0, 32767, 0, -32767, 0, 32767, 0, -32767};

    #12;
    check("reset_value", int'(dataout), 0);

    // Reset behaviour, including asynchronous assertion mid-run
    do_reset(16'd714);
    for (int i = 0; i < 20; i++) step("run_714");
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset", int'(dataout), 0);
    ph = 16'd0;
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    check("post_reset_first", int'(dataout), 0);
    tick();
    check("post_reset_second", int'(dataout), 2210);

    // Quadrature step
    do_reset(16'd16384);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("quadrature", int'(dataout), quad_exp[i]);
    end

    // Unit index step: edge n emits S(n-1)
    do_reset(16'd64);
    for (int n = 1; n <= 1025; n++) begin
      tick();
      case (n)
        1:       check("unit_idx0", int'(dataout), 0);
        2:       check("unit_idx1", int'(dataout), 201);
        3:       check("unit_idx2", int'(dataout), 402);
        129:     check("unit_idx128", int'(dataout), 23170);
        257:     check("unit_idx256", int'(dataout), 32767);
        513:     check("unit_idx512", int'(dataout), 0);
        769:     check("unit_idx768", int'(dataout), -32767);
        1024:    check("unit_idx1023", int'(dataout), -201);
        1025:    check("unit_wrap", int'(dataout), 0);
        default: check("unit_model", int'(dataout), s_ref(n - 1));
      endcase
    end

    // Frozen phase then resume without restart
    do_reset(16'd64);
    for (int i = 0; i < 10; i++) tick();
    freq = 16'd0;
    for (int i = 0; i < 100; i++) begin
      tick();
      check("frozen_hold", int'(dataout), 2009);
    end
    freq = 16'd64;
    tick();
    check("resume_first", int'(dataout), 2009);
    tick();
    check("resume_second", int'(dataout), 2210);

    // Long run: every sample against the model, count rising zero crossings
    do_reset(16'd714);
    cnt  = 0;
    prev = 0;
    for (int i = 0; i < 65536; i++) begin
      step("long_model");
      cur = int'(dataout);
      check("no_min_value", int'(cur == -32768), 0);
      if (prev < 0 && cur >= 0) cnt++;
      prev = cur;
    end
    check("zero_cross_range", int'(cnt >= 713 && cnt <= 715), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
